// File: rtl/muldiv_mul_arbiter.sv
// -----------------------------------------------------------------------------
// muldiv_mul_arbiter
//
// Sequencer and two-port arbiter for the shift-and-add RV32M multiplier.
// Requester 0 is the CPU execute stage and requester 1 is a coprocessor.
// The block accepts one request at a time and decodes the M-extension
// multiply variant into the multiplier's hm/ua/ub controls. It then pulses
// the load strobe, waits for busy to drop, captures the 32-bit result and
// returns it to the granted requester with a one-cycle done pulse.
//
// Optional feature (macro MULCTL_TIMEOUT_EN):
//   When this macro is defined, a CNT_W-bit watchdog counts the WAIT cycles.
//   If busy is still high after TIMEOUT cycles, the block aborts and returns
//   rsp_result = 0 with rsp_err = 1. When the macro is undefined, no counter
//   is built and rsp_err is tied to 0.
//
// Parameters:
//   TIMEOUT     max WAIT cycles before a forced abort (optional feature only)
//   CNT_W       width of the timeout counter, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req_valid[1:0]         per-requester request valid
//   req_op0/1[1:0]         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1_0/1, req_rs2_0/1  operands per requester
//   req_ready[1:0]         accept pulse (combinational, IDLE cycle only)
//   rsp_done[1:0]          one-cycle result-valid pulse to the granted port
//   rsp_result[31:0]       result, held until the next done
//   rsp_err                timeout flag, qualified by rsp_done
//   m_a, m_b, m_ua, m_ub, m_hm, m_load   multiplier controls (registered)
//   m_busy, m_out          multiplier status and result
// -----------------------------------------------------------------------------
module muldiv_mul_arbiter #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    input  logic [31:0] req_rs1_0,
    input  logic [31:0] req_rs1_1,
    input  logic [31:0] req_rs2_0,
    input  logic [31:0] req_rs2_1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_done,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [31:0] m_a,
    output logic [31:0] m_b,
    output logic        m_ua,
    output logic        m_ub,
    output logic        m_hm,
    output logic        m_load,
    input  logic        m_busy,
    input  logic [31:0] m_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Multiplier controls for one op, packed as {hm, ua, ub}.
    // ua/ub = 1 means that operand is unsigned; hm = 1 selects the high word.
    function automatic logic [2:0] decode_op(input logic [1:0] op);
        case (op)
            2'b00:   decode_op = 3'b011;  // MUL: low word, sign irrelevant
            2'b01:   decode_op = 3'b100;  // MULH: signed x signed
            2'b10:   decode_op = 3'b110;  // MULHSU: rs2 (a) unsigned, rs1 (b) signed
            default: decode_op = 3'b111;  // MULHU: unsigned x unsigned
        endcase
    endfunction

    state_t      state_q;
    logic        ptr_q;        // round-robin winner when both ports request
    logic        grant_q;      // port that owns the in-flight operation
    logic [31:0] m_a_q;
    logic [31:0] m_b_q;
    logic        m_ua_q;
    logic        m_ub_q;
    logic        m_hm_q;
    logic        m_load_q;
    logic [1:0]  rsp_done_q;
    logic [31:0] rsp_result_q;

    logic        gnt_idx;
    logic [1:0]  sel_op;
    logic [31:0] sel_rs1;
    logic [31:0] sel_rs2;
    logic [1:0]  done_vec_d;

    // Arbitration: a single requester wins outright. When both request, the
    // pointer decides.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        gnt_idx   = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            gnt_idx = ptr_q;
        end else begin
            gnt_idx = req_valid[1];
        end
        if (state_q == ST_IDLE && req_valid != 2'b00) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_op     = gnt_idx ? req_op1   : req_op0;
    assign sel_rs1    = gnt_idx ? req_rs1_1 : req_rs1_0;
    assign sel_rs2    = gnt_idx ? req_rs2_1 : req_rs2_0;
    assign done_vec_d = grant_q ? 2'b10 : 2'b01;

`ifdef MULCTL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rsp_err_q;
    logic             timeout_d;

    assign cnt_d     = cnt_q + CNT_W'(1);
    assign timeout_d = (cnt_d == CNT_W'(TIMEOUT));
`else
    // The timeout parameters have no effect in this build.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT > 0) && (CNT_W > 0);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the operand and result registers are reset along with the
            // control registers, so every output reads 0 during reset.
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            grant_q      <= 1'b0;
            m_a_q        <= '0;
            m_b_q        <= '0;
            m_ua_q       <= 1'b0;
            m_ub_q       <= 1'b0;
            m_hm_q       <= 1'b0;
            m_load_q     <= 1'b0;
            rsp_done_q   <= 2'b00;
            rsp_result_q <= '0;
`ifdef MULCTL_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            // Load and done are strobes. They fall back to 0 unless a state
            // raises them.
            m_load_q   <= 1'b0;
            rsp_done_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        grant_q <= gnt_idx;
                        if (req_valid == 2'b11) begin
                            ptr_q <= ~gnt_idx;
                        end
                        m_a_q <= sel_rs2;
                        m_b_q <= sel_rs1;
                        {m_hm_q, m_ua_q, m_ub_q} <= decode_op(sel_op);
                        m_load_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef MULCTL_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Operands stay untouched here because m_out depends
                    // combinationally on hm until the capture edge.
                    if (!m_busy) begin
                        rsp_result_q <= m_out;
                        rsp_done_q   <= done_vec_d;
`ifdef MULCTL_TIMEOUT_EN
                        rsp_err_q    <= 1'b0;
`endif
                        state_q      <= ST_DONE;
`ifdef MULCTL_TIMEOUT_EN
                    end else if (timeout_d) begin
                        rsp_result_q <= '0;
                        rsp_done_q   <= done_vec_d;
                        rsp_err_q    <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_a        = m_a_q;
    assign m_b        = m_b_q;
    assign m_ua       = m_ua_q;
    assign m_ub       = m_ub_q;
    assign m_hm       = m_hm_q;
    assign m_load     = m_load_q;
    assign rsp_done   = rsp_done_q;
    assign rsp_result = rsp_result_q;
`ifdef MULCTL_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_mul_arbiter
//
// Directed bench for muldiv_mul_arbiter. The bench includes a behavioural
// multiplier that latches its operands on load and stays busy for 4 cycles.
// It skips busy entirely when a is 0. While busy, m_out shows a poison value.
// -----------------------------------------------------------------------------
module tb_muldiv_mul_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_op0, req_op1;
    logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
    logic [1:0]  req_ready, rsp_done;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [31:0] m_a, m_b;
    logic        m_ua, m_ub, m_hm, m_load;
    logic        m_busy;
    logic [31:0] m_out;

    int n_checks = 0;
    int n_pass   = 0;
    int load_cnt = 0;

    always #5 clk = ~clk;

    muldiv_mul_arbiter #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_op0(req_op0), .req_op1(req_op1),
        .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
        .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
        .req_ready(req_ready), .rsp_done(rsp_done),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .m_a(m_a), .m_b(m_b), .m_ua(m_ua), .m_ub(m_ub), .m_hm(m_hm),
        .m_load(m_load), .m_busy(m_busy), .m_out(m_out)
    );

    // ---------------- behavioural multiplier ----------------
    logic [31:0] la, lb;
    logic        lua, lub;
    logic [3:0]  busy_cnt = '0;
    logic        force_busy = 1'b0;
    logic [63:0] ae, be, prod;

    always @(posedge clk) begin
        if (m_load) begin
            la       <= m_a;
            lb       <= m_b;
            lua      <= m_ua;
            lub      <= m_ub;
            busy_cnt <= (m_a == 32'd0) ? 4'd0 : 4'd4;
            load_cnt <= load_cnt + 1;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

    assign ae     = lua ? {32'd0, la} : {{32{la[31]}}, la};
    assign be     = lub ? {32'd0, lb} : {{32{lb[31]}}, lb};
    assign prod   = ae * be;
    assign m_busy = force_busy | (busy_cnt != 4'd0);
    assign m_out  = m_busy ? 32'hDEAD_BEEF : (m_hm ? prod[63:32] : prod[31:0]);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Issue one request and follow it to its done. This task is called at a
    // negedge in IDLE. Latency counts the cycles from the accepting IDLE cycle
    // to the DONE cycle.
    task automatic run_req(input string name, input int port, input logic [1:0] op,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [2:0] ctrl, input logic [31:0] exp,
                           input int exp_lat, input logic exp_err);
        int t;
        int lat;
        int ld0;
        if (port == 0) begin
            req_op0 = op; req_rs1_0 = rs1; req_rs2_0 = rs2;
        end else begin
            req_op1 = op; req_rs1_1 = rs1; req_rs2_1 = rs2;
        end
        req_valid[port] = 1'b1;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, ":ready"}, 32'(req_ready), 32'(2'b01 << port));
        ld0 = load_cnt;
        @(posedge clk);
        #1 req_valid[port] = 1'b0;
        @(negedge clk);
        check({name, ":m_load"}, 32'(m_load), 32'd1);
        check({name, ":m_a"}, m_a, rs2);
        check({name, ":m_b"}, m_b, rs1);
        check({name, ":hm_ua_ub"}, 32'({m_hm, m_ua, m_ub}), 32'(ctrl));
        lat = 1;
        while (rsp_done == 2'b00 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        check({name, ":done"}, 32'(rsp_done), 32'(2'b01 << port));
        check({name, ":result"}, rsp_result, exp);
        check({name, ":err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ":latency"}, 32'(lat), 32'(exp_lat));
        check({name, ":a_stable"}, m_a, rs2);
        check({name, ":loads"}, 32'(load_cnt - ld0), 32'd1);
        @(negedge clk);
        check({name, ":done_pulse"}, 32'(rsp_done), 32'd0);
        check({name, ":held"}, rsp_result, exp);
    endtask

    // Operand tables for the round-robin run. Both ports stay valid throughout.
    logic [31:0] rr_rs1 [4] = '{32'd3, 32'd9, 32'd100, 32'h0001_0000};
    logic [31:0] rr_rs2 [4] = '{32'd4, 32'd9, 32'd200, 32'h0001_0000};
    logic [31:0] rr_exp [4] = '{32'd12, 32'd81, 32'd20000, 32'd0};

    initial begin
        int t;
        int sum_done;
        resetn    = 1'b0;
        req_valid = 2'b00;
        req_op0   = 2'b00; req_op1   = 2'b00;
        req_rs1_0 = '0;    req_rs1_1 = '0;
        req_rs2_0 = '0;    req_rs2_1 = '0;
        #1;
        check("rst:ready", 32'(req_ready), 32'd0);
        check("rst:done", 32'(rsp_done), 32'd0);
        check("rst:result", rsp_result, 32'd0);
        check("rst:m_ctl", 32'({m_load, m_hm, m_ua, m_ub, rsp_err}), 32'd0);
        check("rst:m_ab", m_a | m_b, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // ctrl = {hm, ua, ub}; latency 7 = IDLE + ISSUE + 4 busy + 1 idle WAIT.
        run_req("mul",    0, 2'b00, 32'd7,        32'd6,        3'b011, 32'd42,        7, 1'b0);
        run_req("mulh",   0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 3'b100, 32'hFFFF_FFFF, 7, 1'b0);
        run_req("mulhu",  0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 3'b111, 32'h0000_0001, 7, 1'b0);
        run_req("mulhsu", 1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h8000_0000, 7, 1'b0);

        // Reset in the middle of WAIT: the request is dropped and everything
        // clears.
        req_op0 = 2'b00; req_rs1_0 = 32'd3; req_rs2_0 = 32'd5;
        req_valid[0] = 1'b1;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst:result", rsp_result, 32'd0);
        check("midrst:m_ctl", 32'({m_load, m_hm, m_ua, m_ub, rsp_err}), 32'd0);
        check("midrst:m_ab", m_a | m_b, 32'd0);
        check("midrst:done", 32'(rsp_done), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sum_done = 0;
        repeat (10) begin
            @(negedge clk);
            sum_done += int'(rsp_done != 2'b00);
        end
        check("midrst:no_done", 32'(sum_done), 32'd0);
        run_req("postrst", 1, 2'b00, 32'd11,  32'd13, 3'b011, 32'd143, 7, 1'b0);
        run_req("zero",    0, 2'b00, 32'd5,   32'd0,  3'b011, 32'd0,   3, 1'b0);

        // Round robin with both ports continuously valid. The grants go
        // 0, 1, 0, 1.
        req_op0 = 2'b00; req_op1 = 2'b00;
        req_rs1_0 = rr_rs1[0]; req_rs2_0 = rr_rs2[0];
        req_rs1_1 = rr_rs1[1]; req_rs2_1 = rr_rs2[1];
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = k % 2;
            t = 0;
            while (req_ready == 2'b00 && t < 20) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("rr%0d:ready", k), 32'(req_ready), 32'(2'b01 << p));
            @(posedge clk);
            #1;
            if (k < 2) begin
                if (p == 0) begin req_rs1_0 = rr_rs1[2]; req_rs2_0 = rr_rs2[2]; end
                else        begin req_rs1_1 = rr_rs1[3]; req_rs2_1 = rr_rs2[3]; end
            end else begin
                req_valid[p] = 1'b0;
            end
            t = 0;
            while (rsp_done == 2'b00 && t < 80) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("rr%0d:done", k), 32'(rsp_done), 32'(2'b01 << p));
            check($sformatf("rr%0d:result", k), rsp_result, rr_exp[k]);
        end
        @(negedge clk);

`ifdef MULCTL_TIMEOUT_EN
        // Stuck multiplier: abort after 40 WAIT cycles, so the latency is
        // 2 + 40.
        force_busy = 1'b1;
        run_req("timeout", 0, 2'b00, 32'd1, 32'd2, 3'b011, 32'd0, 42, 1'b1);
        force_busy = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
